// File: rtl/reg_grp_fsm.sv
// reg_grp_fsm: fans one upstream register bus out to NUM_OUTPUTS
// downstream channels chosen by the top address bits.
//
// Ports:
//   clk, reset_n           clock, async active-low reset
//   reg_req/rd_wr_L/addr/wr_data -> upstream request
//   reg_ack, reg_rd_data   <- upstream response (held until reg_req drops)
//   local_reg_*            per-channel request bundle, channel j in slice j
//   local_reg_ack/rd_data  per-channel response
//   timeout_pulse          one-cycle strobe per downstream timeout
//   timeout_count          saturating count of timeouts
module reg_grp_fsm #(
    parameter int REG_ADDR_BITS  = 10,
    parameter int NUM_OUTPUTS    = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter logic [DATA_WIDTH-1:0] UNMAPPED_DATA = 32'hDEAD_BEEF,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA  = 32'hDEAD_0000,
    localparam int SEL_BITS   = $clog2(NUM_OUTPUTS),
    localparam int LOCAL_BITS = REG_ADDR_BITS - SEL_BITS
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              reg_req,
    input  logic                              reg_rd_wr_L,
    input  logic [REG_ADDR_BITS-1:0]          reg_addr,
    input  logic [DATA_WIDTH-1:0]             reg_wr_data,
    output logic                              reg_ack,
    output logic [DATA_WIDTH-1:0]             reg_rd_data,
    output logic [NUM_OUTPUTS-1:0]            local_reg_req,
    output logic [NUM_OUTPUTS-1:0]            local_reg_rd_wr_L,
    output logic [NUM_OUTPUTS*LOCAL_BITS-1:0] local_reg_addr,
    output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] local_reg_wr_data,
    input  logic [NUM_OUTPUTS-1:0]            local_reg_ack,
    input  logic [NUM_OUTPUTS*DATA_WIDTH-1:0] local_reg_rd_data,
    output logic                              timeout_pulse,
    output logic [15:0]                       timeout_count
);

    localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t                            r_state;
    logic [SEL_BITS-1:0]               r_sel;
    logic [CNT_BITS-1:0]               r_cnt;
    logic                              r_ack;
    logic [DATA_WIDTH-1:0]             r_rd_data;
    logic [NUM_OUTPUTS-1:0]            r_lreq;
    logic [NUM_OUTPUTS-1:0]            r_lrdwr;
    logic [NUM_OUTPUTS*LOCAL_BITS-1:0] r_laddr;
    logic [NUM_OUTPUTS*DATA_WIDTH-1:0] r_lwdata;
    logic                              r_tmo_pulse;
    logic [15:0]                       r_tmo_count;

    logic [SEL_BITS-1:0]   w_sel;
    logic                  w_mapped;
    logic                  w_sel_ack;
    logic [DATA_WIDTH-1:0] w_sel_rdata;
    logic                  w_tmo;

    assign w_sel       = reg_addr[REG_ADDR_BITS-1 -: SEL_BITS];
    assign w_mapped    = 32'(w_sel) < 32'(NUM_OUTPUTS);
    // Only the latched channel's response matters; the rest are ignored.
    assign w_sel_ack   = local_reg_ack[r_sel];
    assign w_sel_rdata = local_reg_rd_data[r_sel*DATA_WIDTH +: DATA_WIDTH];
    assign w_tmo       = r_cnt == CNT_BITS'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_ack       <= 1'b0;
            r_rd_data   <= '0;
            r_lreq      <= '0;
            r_lrdwr     <= '0;
            r_laddr     <= '0;
            r_lwdata    <= '0;
            r_tmo_pulse <= 1'b0;
            r_tmo_count <= '0;
        end else begin
            r_tmo_pulse <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (reg_req) begin
                        if (w_mapped) begin
                            r_sel          <= w_sel;
                            r_cnt          <= '0;
                            r_lreq[w_sel]  <= 1'b1;
                            r_lrdwr[w_sel] <= reg_rd_wr_L;
                            r_laddr[w_sel*LOCAL_BITS +: LOCAL_BITS]
                                <= reg_addr[LOCAL_BITS-1:0];
                            r_lwdata[w_sel*DATA_WIDTH +: DATA_WIDTH]
                                <= reg_wr_data;
                            r_state        <= S_WAIT;
                        end else begin
                            r_ack     <= 1'b1;
                            r_rd_data <= UNMAPPED_DATA;
                            r_state   <= S_ACK;
                        end
                    end
                end
                S_WAIT: begin
                    // Any exit from WAIT returns every channel to all-zero.
                    if (!reg_req) begin
                        r_lreq   <= '0;
                        r_lrdwr  <= '0;
                        r_laddr  <= '0;
                        r_lwdata <= '0;
                        r_state  <= S_IDLE;
                    end else if (w_sel_ack) begin
                        r_lreq    <= '0;
                        r_lrdwr   <= '0;
                        r_laddr   <= '0;
                        r_lwdata  <= '0;
                        r_ack     <= 1'b1;
                        r_rd_data <= w_sel_rdata;
                        r_state   <= S_ACK;
                    end else if (w_tmo) begin
                        r_lreq      <= '0;
                        r_lrdwr     <= '0;
                        r_laddr     <= '0;
                        r_lwdata    <= '0;
                        r_ack       <= 1'b1;
                        r_rd_data   <= TIMEOUT_DATA;
                        r_tmo_pulse <= 1'b1;
                        if (r_tmo_count != 16'hFFFF)
                            r_tmo_count <= r_tmo_count + 16'd1;
                        r_state     <= S_ACK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ACK: begin
                    if (!reg_req) begin
                        r_ack   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign reg_ack           = r_ack;
    assign reg_rd_data       = r_rd_data;
    assign local_reg_req     = r_lreq;
    assign local_reg_rd_wr_L = r_lrdwr;
    assign local_reg_addr    = r_laddr;
    assign local_reg_wr_data = r_lwdata;
    assign timeout_pulse     = r_tmo_pulse;
    assign timeout_count     = r_tmo_count;

endmodule

// File: tb/tb_reg_grp_fsm.sv
// tb_reg_grp_fsm: directed scoreboard bench for reg_grp_fsm.
// u_dut uses 4 channels, u_dut3 uses 3 channels for the unmapped case.
module tb_reg_grp_fsm;

    logic clk;
    logic reset_n;

    logic         req, rdwr, ack;
    logic [9:0]   addr;
    logic [31:0]  wdata, rdata;
    logic [3:0]   lreq, lrdwr, lack;
    logic [31:0]  laddr;
    logic [127:0] lwdata, lrdata;
    logic         tpulse;
    logic [15:0]  tcount;

    logic         req3, rdwr3, ack3;
    logic [9:0]   addr3;
    logic [31:0]  wdata3, rdata3;
    logic [2:0]   lreq3, lrdwr3, lack3;
    logic [23:0]  laddr3;
    logic [95:0]  lwdata3, lrdata3;
    logic         tpulse3;
    logic [15:0]  tcount3;

    int n_cmp = 0;
    int n_err = 0;
    int n_pulse = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_q3[$];
    logic ack_d = 1'b0;
    logic ack3_d = 1'b0;

    reg_grp_fsm u_dut (
        .clk(clk), .reset_n(reset_n),
        .reg_req(req), .reg_rd_wr_L(rdwr), .reg_addr(addr),
        .reg_wr_data(wdata), .reg_ack(ack), .reg_rd_data(rdata),
        .local_reg_req(lreq), .local_reg_rd_wr_L(lrdwr),
        .local_reg_addr(laddr), .local_reg_wr_data(lwdata),
        .local_reg_ack(lack), .local_reg_rd_data(lrdata),
        .timeout_pulse(tpulse), .timeout_count(tcount)
    );

    reg_grp_fsm #(.NUM_OUTPUTS(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n),
        .reg_req(req3), .reg_rd_wr_L(rdwr3), .reg_addr(addr3),
        .reg_wr_data(wdata3), .reg_ack(ack3), .reg_rd_data(rdata3),
        .local_reg_req(lreq3), .local_reg_rd_wr_L(lrdwr3),
        .local_reg_addr(laddr3), .local_reg_wr_data(lwdata3),
        .local_reg_ack(lack3), .local_reg_rd_data(lrdata3),
        .timeout_pulse(tpulse3), .timeout_count(tcount3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitors: each rising reg_ack retires one expected word.
    always @(negedge clk) begin
        if (ack && !ack_d) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ack: got data %0h expected none",
                         rdata);
            end else begin
                chk("rd_data", rdata, exp_q.pop_front());
            end
        end
        ack_d <= ack;
        if (tpulse) n_pulse++;
    end

    always @(negedge clk) begin
        if (ack3 && !ack3_d) begin
            if (exp_q3.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ack3: got data %0h expected none",
                         rdata3);
            end else begin
                chk("rd_data3", rdata3, exp_q3.pop_front());
            end
        end
        ack3_d <= ack3;
    end

    initial begin
        int n;
        reset_n = 1'b0;
        req = 0; rdwr = 0; addr = '0; wdata = '0; lack = '0; lrdata = '0;
        req3 = 0; rdwr3 = 0; addr3 = '0; wdata3 = '0; lack3 = '0;
        lrdata3 = '0;
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_lreq", lreq, 0);
        chk("rst_tcount", tcount, 0);
        chk("rst_rdata", rdata, 0);
        #20;
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Read ch2, ack three cycles after the request appears
        req = 1; rdwr = 1; addr = 10'h2A5;
        exp_q.push_back(32'h1234_5678);
        tick();
        chk("t1_lreq", lreq, 4'b0100);
        chk("t1_laddr", laddr, 32'h00A5_0000);
        chk("t1_lrdwr", lrdwr, 4'b0100);
        tick();
        tick();
        chk("t1_no_ack_yet", ack, 0);
        lack = 4'b0100;
        lrdata[95:64] = 32'h1234_5678;
        tick();
        chk("t1_ack", ack, 1);
        chk("t1_lreq_drop", lreq, 0);
        lack = '0; lrdata = '0;
        tick();
        chk("t1_ack_held", ack, 1);
        req = 0;
        tick();
        chk("t1_ack_drop", ack, 0);

        // Unmapped select on the 3-channel instance
        req3 = 1; rdwr3 = 1; addr3 = 10'h3FF;
        exp_q3.push_back(32'hDEAD_BEEF);
        tick();
        chk("t2_ack", ack3, 1);
        chk("t2_lreq", lreq3, 0);
        req3 = 0;
        tick();
        chk("t2_ack_drop", ack3, 0);
        chk("t2_rdata_hold", rdata3, 32'hDEAD_BEEF);

        // Write ch1 with no ack: timeout; stray acks on other channels
        req = 1; rdwr = 0; addr = 10'h13C; wdata = 32'hCAFE_F00D;
        exp_q.push_back(32'hDEAD_0000);
        tick();
        chk("t3_lreq", lreq, 4'b0010);
        chk("t3_lrdwr", lrdwr, 0);
        chk("t3_laddr", laddr, 32'h0000_3C00);
        chk("t3_lwdata", lwdata, 128'(32'hCAFE_F00D) << 32);
        lack = 4'b1101;
        lrdata = {4{32'h5555_AAAA}};
        n = 0;
        while (lreq[1] && n < 200) begin
            n++;
            tick();
        end
        lack = '0; lrdata = '0;
        chk("t3_req_cycles", n, 64);
        chk("t3_ack", ack, 1);
        chk("t3_pulse", tpulse, 1);
        chk("t3_tcount", tcount, 1);
        tick();
        chk("t3_pulse_once", tpulse, 0);
        req = 0;
        tick();
        chk("t3_ack_drop", ack, 0);

        // Ack on exactly the timeout cycle: ack wins
        req = 1; rdwr = 1; addr = 10'h055; wdata = '0;
        exp_q.push_back(32'h5A5A_A5A5);
        tick();
        for (int i = 0; i < 63; i++) tick();
        chk("t4_no_early_tmo", ack, 0);
        lack = 4'b0001;
        lrdata[31:0] = 32'h5A5A_A5A5;
        tick();
        chk("t4_ack", ack, 1);
        chk("t4_no_pulse", tpulse, 0);
        chk("t4_tcount", tcount, 1);
        lack = '0; lrdata = '0;
        req = 0;
        tick();

        // Upstream abort after five cycles on ch0
        req = 1; rdwr = 0; addr = 10'h012; wdata = 32'h0F0F_0F0F;
        tick();
        chk("t5_laddr", laddr, 32'h0000_0012);
        for (int i = 0; i < 4; i++) tick();
        req = 0;
        tick();
        chk("t5_lreq_drop", lreq, 0);
        chk("t5_no_ack", ack, 0);
        for (int i = 0; i < 3; i++) tick();
        chk("t5_no_ack_late", ack, 0);
        chk("t5_tcount", tcount, 1);

        // Reset mid-WAIT on ch3, then a clean read on ch3
        req = 1; rdwr = 1; addr = 10'h3C7;
        tick();
        chk("t6_lreq", lreq, 4'b1000);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_lreq", lreq, 0);
        chk("t6_rst_laddr", laddr, 0);
        chk("t6_rst_tcount", tcount, 0);
        chk("t6_rst_ack", ack, 0);
        req = 0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        req = 1; rdwr = 1; addr = 10'h3C7;
        exp_q.push_back(32'h3333_CCCC);
        tick();
        chk("t6_post_lreq", lreq, 4'b1000);
        chk("t6_post_laddr", laddr, 32'hC700_0000);
        lack = 4'b1000;
        lrdata[127:96] = 32'h3333_CCCC;
        tick();
        chk("t6_post_ack", ack, 1);
        lack = '0; lrdata = '0;
        req = 0;
        tick();
        chk("t6_post_drop", ack, 0);

        tick();
        tick();
        chk("pulse_total", n_pulse, 1);
        chk("q_empty", exp_q.size(), 0);
        chk("q3_empty", exp_q3.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
